// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic-library types, constants and helpers
//
// Purpose : common definitions for the bit-serial arithmetic blocks.
// Contents: sub_state_t FSM encoding, ARITH_WIDTH default operand width,
//           clog2() for sizing counters from parameters.
package arith_pkg;

  localparam int ARITH_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  // Smallest r with 2**r >= value; usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_subtractor_mux.sv
// rtl/full_subtractor_mux.sv - full-subtractor cell built from two 4:1 muxes
//
// Purpose : one-bit a - b - bi, d = a^b^bi, bo = ~a&b | ~a&bi | b&bi.
// Ports   : a, b, bi inputs; d difference bit, bo borrow-out.
module full_subtractor_mux (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  logic [1:0] sel;
  logic       bi_n;

  assign sel  = {a, b};
  assign bi_n = ~bi;

  // Difference: inverts bi exactly when a != b.
  mux4to1 u_d_mux (
    .sel (sel),
    .d0  (bi),
    .d1  (bi_n),
    .d2  (bi_n),
    .d3  (bi),
    .y   (d)
  );

  // Borrow: a=0,b=1 always borrows; a=1,b=0 never; equal bits propagate bi.
  mux4to1 u_bo_mux (
    .sel (sel),
    .d0  (bi),
    .d1  (1'b1),
    .d2  (1'b0),
    .d3  (bi),
    .y   (bo)
  );

endmodule

// File: rtl/mux4to1.sv
// rtl/mux4to1.sv - single-bit 4:1 multiplexer
//
// Purpose : library 4:1 mux, building block of the mux-based adder/subtractor cells.
// Ports   : sel [1:0] select (sel[1] is MSB), d0..d3 data inputs, y output.
module mux4to1 (
  input  logic [1:0] sel,
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  output logic       y
);

  always_comb begin
    y = d0;
    case (sel)
      2'b00:   y = d0;
      2'b01:   y = d1;
      2'b10:   y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/serial_subtractor_mux.sv
// rtl/serial_subtractor_mux.sv - bit-serial N-bit subtractor, LSB first
//
// Purpose : diff = a - b - bin over WIDTH clocks using one full_subtractor_mux cell.
// Ports   : clk, rst_n (async active-low), start, a, b, bin in;
//           busy, done (1-cycle pulse), diff, bout out;
//           ovf out only when SUB_OVERFLOW_EN is defined (signed overflow).
// Macro   : SUB_OVERFLOW_EN
module serial_subtractor_mux
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = clog2(WIDTH + 1);

  sub_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             cell_d, cell_bo;
  logic [WIDTH:0]   diff_shift;

`ifdef SUB_OVERFLOW_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  full_subtractor_mux u_cell (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .bi (borrow_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // New bit enters at the MSB; after WIDTH shifts the first bit sits at bit 0.
  assign diff_shift = {cell_d, diff_q} >> 1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
`ifdef SUB_OVERFLOW_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = bin;
          cnt_d    = '0;
          state_d  = SHIFT;
`ifdef SUB_OVERFLOW_EN
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        diff_d   = diff_shift[WIDTH-1:0];
        borrow_d = cell_bo;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          bout_d  = cell_bo;
`ifdef SUB_OVERFLOW_EN
          // cell_d is the result MSB being shifted in on this edge.
          ovf_d   = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
`ifdef SUB_OVERFLOW_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SUB_OVERFLOW_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor_mux.md
Name: serial_subtractor_mux

Overview:
Bit-serial N-bit subtractor. It computes diff = a - b - bin, processing one bit per clock, LSB first.
Each bit is handled by a full-subtractor cell built from two 4:1 muxes. This cell is the inverse counterpart of the team's mux-based full adder.
It sits beside the adder in the arithmetic library and serves area-constrained datapaths that can tolerate N-cycle latency.
Operands are accepted with a start/busy/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 1..32).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE.
a  input  WIDTH  minuend; latched when start is accepted.
b  input  WIDTH  subtrahend; latched when start is accepted.
bin  input  1  borrow-in; latched when start is accepted.
busy  output  1  high while the subtraction is in progress.
done  output  1  one-cycle pulse; diff and bout are valid.
diff  output  WIDTH  result, a - b - bin, modulo 2^WIDTH.
bout  output  1  final borrow-out; 1 when a < b + bin (unsigned).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, diff=0, bout=0.
  - Internal shift registers and bit counter cleared.
- States: IDLE, SHIFT, DONE. Bit counter width is clog2(WIDTH+1).
- IDLE:
  - If start=1 at a rising edge: latch a, b and bin into shift registers, latch bin as the running borrow, counter=0, go to SHIFT, busy=1.
  - If start=0: remain in IDLE; diff and bout hold their last values.
- SHIFT: on each rising edge:
  - Feed a_sh[0], b_sh[0] and borrow into the cell.
  - Shift the cell's d output into the MSB of the diff register (right shift).
  - borrow <= cell's bo output.
  - Shift a_sh and b_sh right by one.
  - Counter increments.
  - When the counter reaches WIDTH-1 on this edge, go to DONE and load bout from the cell's bo output.
- DONE: exactly one cycle.
  - done=1, busy=0; diff is complete (bit0 = first processed bit).
  - Next edge: go to IDLE, done=0.
- Latency:
  - Start accepted at edge E0.
  - busy high from edge E0 to edge E0+WIDTH.
  - done high for the cycle after edge E0+WIDTH.
  - Next start is accepted at edge E0+WIDTH+2 at the earliest.
- start while in SHIFT or DONE: ignored; no latching, no queuing.
- Operand inputs are don't-care except at the accepting edge; changing them mid-operation has no effect.
- WIDTH=1: SHIFT lasts one edge, then DONE.
- rst_n asserted mid-operation: immediate abort to the reset values above; no done pulse is emitted.
- Cell function:
  - d = a ^ b ^ bi.
  - bo = (~a & b) | (~a & bi) | (b & bi).
  - Select lines are {a,b} (a is the MSB select).
  - d mux data inputs, in select order 00, 01, 10, 11: bi, ~bi, ~bi, bi.
  - bo mux data inputs, in select order 00, 01, 10, 11: bi, 1, 0, bi.

Optional Feature:
Macro SUB_OVERFLOW_EN.
- Defined: adds output port ovf (1 bit, reset 0), loaded on the same edge as bout and held until the next accepted start.
  - ovf = signed two's-complement overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
  - The operand MSBs used are the values latched at start.
- Not defined: no ovf port and no associated logic; all other behaviour is identical.

Decomposition:
- Shared package arith_pkg holds:
  - the state enum sub_state_t {IDLE, SHIFT, DONE};
  - the localparam function clog2;
  - the default WIDTH constant.
- One sub-module: full_subtractor_mux (inputs a, b, bi; outputs d, bo), built from two instances of the existing mux4to1.
- The top instantiates one full_subtractor_mux plus the FSM, counter and shift registers.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x3C, bin=0, start pulse -> busy for 8 cycles, then done=1 for one cycle with diff=0x1E, bout=0.
2. a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; with SUB_OVERFLOW_EN, ovf=0.
3. a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
4. Start a=0x20, b=0x01. Hold start=1 with a=0xFF, b=0xFF for cycles 2-9 -> only one done pulse, with diff=0x1F. A new operation starts only after IDLE is re-entered.
5. Start a=0x80, b=0x01. Assert rst_n=0 at cycle 4 -> busy=0, done=0, diff=0 immediately; no done pulse follows. After release, a fresh start gives diff=0x7F (with SUB_OVERFLOW_EN, ovf=1).
6. Exhaustive check of full_subtractor_mux over all 8 input combinations -> d and bo match the equations in Behaviour.
